// File: rtl/local_hist_predictor_pkg.sv
// Shared constants, state encoding and helper functions for local_hist_predictor.
// Supplies a default `ADDR_WIDTH when the build does not define one.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package pred_pkg;

    localparam int ADDR_W        = `ADDR_WIDTH;
    localparam int CNT_WIDTH_DEF = 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } pred_state_e;

    // Weakly-not-taken: the largest value whose MSB is still 0.
    function automatic logic [31:0] wnt(input int unsigned width);
        return (width <= 1) ? 32'd0 : ((32'd1 << (width - 1)) - 32'd1);
    endfunction

    // Branch PCs are word aligned, so the two LSBs carry no information.
    function automatic logic [ADDR_W-1:0] pc_to_idx(input logic [ADDR_W-1:0] pc,
                                                   input int unsigned     idx_bits);
        return (pc >> 2) & ((ADDR_W'(1) << idx_bits) - ADDR_W'(1));
    endfunction

    function automatic logic [31:0] sat_update(input logic [31:0]   cnt,
                                               input logic          taken,
                                               input int unsigned   width = CNT_WIDTH_DEF);
        logic [31:0] max_v;
        max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        if (taken)
            return (cnt == max_v) ? cnt : cnt + 32'd1;
        return (cnt == 32'd0) ? cnt : cnt - 32'd1;
    endfunction

endpackage

// File: rtl/local_hist_predictor_pht_bank.sv
// Pattern history table: one lookup read port and one write port shared between the
// init sweep and commit-time saturating updates. Reads return pre-write contents.
module pred_pht_bank
    import pred_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int CNT_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 i_sweep_en,
    input  logic [ADDR_BITS-1:0] i_sweep_addr,
    input  logic                 i_upd_en,
    input  logic [ADDR_BITS-1:0] i_upd_addr,
    input  logic                 i_upd_taken,
    input  logic [ADDR_BITS-1:0] i_rd_addr,
    output logic [CNT_WIDTH-1:0] o_rd_cnt
);

    localparam logic [CNT_WIDTH-1:0] WNT = CNT_WIDTH'(wnt(CNT_WIDTH));

    logic [CNT_WIDTH-1:0] r_pht [2**ADDR_BITS];

    logic                 w_wr_en;
    logic [ADDR_BITS-1:0] w_wr_addr;
    logic [CNT_WIDTH-1:0] w_wr_data;

    // Sweep and update never coincide (the FSM only sweeps in INIT), so the sweep simply wins.
    always_comb begin
        w_wr_en   = i_sweep_en | i_upd_en;
        w_wr_addr = i_sweep_en ? i_sweep_addr : i_upd_addr;
        w_wr_data = i_sweep_en ? WNT
                  : CNT_WIDTH'(sat_update(32'(r_pht[i_upd_addr]), i_upd_taken, CNT_WIDTH));
    end

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_pht[w_wr_addr] <= w_wr_data;
    end

    assign o_rd_cnt = r_pht[i_rd_addr];

endmodule

// File: rtl/local_hist_predictor.sv
// Two-level local-history branch predictor: per-PC history table feeding a PHT of counters.
// Optional build macro PRED_STATS_EN adds lookup/mispredict statistics counters.
module local_hist_predictor
    import pred_pkg::*;
#(
    parameter  int IDX_BITS   = 6,
    parameter  int HIST_WIDTH = 4,
    parameter  int CNT_WIDTH  = 2,
    localparam int PHT_DEPTH  = 2**(IDX_BITS+HIST_WIDTH)
) (
    input  logic              clk,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              if2pred_en,
    input  logic [ADDR_W-1:0] if2pred_pc,
    output logic              pred2if_valid,
    output logic              pred2if_taken,
    output logic              pred_ready,
    input  logic              rob2pred_en,
    input  logic [ADDR_W-1:0] rob2pred_pc,
    input  logic              rob2pred_taken,
    input  logic              rob2pred_mispredict
`ifdef PRED_STATS_EN
    ,
    output logic [31:0]       pred_lookup_cnt,
    output logic [31:0]       pred_mispred_cnt
`endif
);

    localparam int PTR_W     = IDX_BITS + HIST_WIDTH;
    localparam int BHT_DEPTH = 2**IDX_BITS;

    pred_state_e          r_state;
    pred_state_e          w_state_next;
    logic [PTR_W-1:0]     r_sweep_ptr;
    logic                 w_sweep_en;
    logic                 w_sweep_last;
    logic                 w_lookup_acc;
    logic                 w_update_acc;

    logic [HIST_WIDTH-1:0] r_bht [BHT_DEPTH];
    logic [IDX_BITS-1:0]   w_lk_idx;
    logic [IDX_BITS-1:0]   w_up_idx;
    logic [HIST_WIDTH-1:0] w_lk_hist;
    logic [HIST_WIDTH-1:0] w_up_hist;
    logic [HIST_WIDTH:0]   w_hist_shift;
    logic [CNT_WIDTH-1:0]  w_rd_cnt;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst_in)
            r_state <= ST_INIT;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (r_state == ST_INIT && rdy_in && w_sweep_last)
            w_state_next = ST_RUN;
    end

    always_comb begin
        pred_ready   = (r_state == ST_RUN);
        w_sweep_en   = !rst_in && rdy_in && (r_state == ST_INIT);
        w_lookup_acc = !rst_in && rdy_in && (r_state == ST_RUN) && if2pred_en;
        w_update_acc = !rst_in && rdy_in && (r_state == ST_RUN) && rob2pred_en;
    end

    assign w_sweep_last = (r_sweep_ptr == PTR_W'(PHT_DEPTH - 1));

    always_ff @(posedge clk) begin
        if (rst_in)
            r_sweep_ptr <= '0;
        else if (w_sweep_en)
            r_sweep_ptr <= r_sweep_ptr + 1'b1;
    end

    // ---------------- BHT ----------------
    assign w_lk_idx  = IDX_BITS'(pc_to_idx(if2pred_pc, IDX_BITS));
    assign w_up_idx  = IDX_BITS'(pc_to_idx(rob2pred_pc, IDX_BITS));
    assign w_lk_hist = r_bht[w_lk_idx];
    assign w_up_hist = r_bht[w_up_idx];
    // Shifting through a one-bit-wider vector also covers HIST_WIDTH == 1.
    assign w_hist_shift = {w_up_hist, rob2pred_taken};

    always_ff @(posedge clk) begin
        if (w_sweep_en && (r_sweep_ptr < PTR_W'(BHT_DEPTH)))
            r_bht[r_sweep_ptr[IDX_BITS-1:0]] <= '0;
        else if (w_update_acc)
            r_bht[w_up_idx] <= w_hist_shift[HIST_WIDTH-1:0];
    end

    // ---------------- PHT ----------------
    pred_pht_bank #(
        .ADDR_BITS (PTR_W),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_pht (
        .clk          (clk),
        .i_sweep_en   (w_sweep_en),
        .i_sweep_addr (r_sweep_ptr),
        .i_upd_en     (w_update_acc),
        .i_upd_addr   ({w_up_idx, w_up_hist}),
        .i_upd_taken  (rob2pred_taken),
        .i_rd_addr    ({w_lk_idx, w_lk_hist}),
        .o_rd_cnt     (w_rd_cnt)
    );

    // ---------------- Lookup result ----------------
    always_ff @(posedge clk) begin
        if (rst_in) begin
            pred2if_valid <= 1'b0;
            pred2if_taken <= 1'b0;
        end else if (rdy_in) begin
            pred2if_valid <= w_lookup_acc;
            if (w_lookup_acc)
                pred2if_taken <= w_rd_cnt[CNT_WIDTH-1];
        end
    end

`ifdef PRED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst_in) begin
            pred_lookup_cnt  <= '0;
            pred_mispred_cnt <= '0;
        end else begin
            if (w_lookup_acc && pred_lookup_cnt != 32'hFFFF_FFFF)
                pred_lookup_cnt <= pred_lookup_cnt + 32'd1;
            if (w_update_acc && rob2pred_mispredict && pred_mispred_cnt != 32'hFFFF_FFFF)
                pred_mispred_cnt <= pred_mispred_cnt + 32'd1;
        end
    end
`else
    logic w_unused_mispredict;
    assign w_unused_mispredict = rob2pred_mispredict;
`endif

endmodule

// File: doc/local_hist_predictor.md
Name: local_hist_predictor

Overview:
- Parametrised two-level local-history branch predictor, successor to the fixed 64x16 two-bit predictor.
- Sits between IF (lookup) and ROB (training at commit).
- Adds configurable history/counter widths, correct saturating counters, word-aligned indexing, registered one-cycle lookup with valid, and a reset sweep state machine so the tables can map to RAM.

Parameters:
- IDX_BITS, 6, log2 of BHT entries; index = PC[IDX_BITS+1:2].
- HIST_WIDTH, 4, local history bits per BHT entry (>=1).
- CNT_WIDTH, 2, saturating counter width (>=1).
- PHT_DEPTH, 2**(IDX_BITS+HIST_WIDTH), derived; do not override.

Ports:
- clk  in  1  clock.
- rst_in  in  1  synchronous active-high reset.
- rdy_in  in  1  global enable; when low, all state and outputs freeze.
- if2pred_en  in  1  lookup request.
- if2pred_pc  in  `ADDR_WIDTH  lookup PC.
- pred2if_valid  out  1  one-cycle pulse, result of the lookup accepted last cycle.
- pred2if_taken  out  1  prediction (counter MSB).
- pred_ready  out  1  high when init sweep is done and requests are accepted.
- rob2pred_en  in  1  commit-time training strobe.
- rob2pred_pc  in  `ADDR_WIDTH  committed branch PC.
- rob2pred_taken  in  1  actual outcome.
- rob2pred_mispredict  in  1  committed branch was mispredicted (used only by the optional feature).

Behaviour:
- States: INIT, RUN.
- rst_in=1: state<=INIT, sweep_ptr<=0, pred2if_valid<=0, pred2if_taken<=0, pred_ready<=0. This applies mid-operation and mid-sweep, and restarts the sweep. In-flight lookups are discarded.
- INIT:
  - Each rdy_in cycle: PHT[sweep_ptr]<=WNT, where WNT = 2**(CNT_WIDTH-1)-1. For CNT_WIDTH=1, WNT=0.
  - BHT[sweep_ptr[IDX_BITS-1:0]]<=0 while sweep_ptr<2**IDX_BITS.
  - sweep_ptr++.
  - After writing PHT_DEPTH-1: state<=RUN, pred_ready<=1. With defaults this takes 1024 cycles.
  - Lookups and updates arriving in INIT are ignored.
- Lookup (RUN, rdy_in, if2pred_en):
  - idx=if2pred_pc[IDX_BITS+1:2], h=BHT[idx].
  - Next cycle: pred2if_valid=1, pred2if_taken=PHT[{idx,h}][CNT_WIDTH-1].
  - Otherwise pred2if_valid=0 next cycle, and pred2if_taken holds its last value.
  - rdy_in low: valid and taken hold their values; no new acceptance.
- Update (RUN, rdy_in, rob2pred_en):
  - u=rob2pred_pc[IDX_BITS+1:2], h=BHT[u].
  - PHT[{u,h}]: if taken, increment saturating at all-ones; else decrement saturating at 0.
  - BHT[u]<={h[HIST_WIDTH-2:0], taken}: newest bit in LSB. For HIST_WIDTH=1, BHT[u]<=taken.
- Simultaneous lookup and update in the same cycle:
  - Both are performed.
  - The lookup sees pre-update BHT and PHT values (read-before-write), including when the index matches.
- One lookup and one update per cycle maximum; there is no backpressure beyond pred_ready.

Optional Feature:
- Macro PRED_STATS_EN.
- When defined, adds outputs pred_lookup_cnt[31:0] and pred_mispred_cnt[31:0]:
  - Reset to 0, and also cleared on rst_in.
  - pred_lookup_cnt increments per accepted lookup.
  - pred_mispred_cnt increments per accepted update with rob2pred_mispredict=1.
  - Both saturate at 32'hFFFF_FFFF.
  - Neither counts during INIT.
- When undefined: no ports, no logic, and rob2pred_mispredict is unused.

Decomposition:
- Shared package (pred_pkg) holds:
  - counter width constants and WNT.
  - index-extract function pc_to_idx.
  - saturating inc/dec function sat_update(cnt, taken).
  - state encoding INIT/RUN.
- One natural sub-module, pred_pht_bank:
  - PHT storage with one read port and one write port, read-before-write.
  - Sweep-write mux.
  - The top instantiates it and owns BHT, FSM and output registers.

Test Plan (defaults):
- Reset for 2 cycles, then idle -> pred_ready low for exactly 1024 rdy_in cycles, then high.
  - First lookup of PC 0x100 -> valid next cycle, taken=0.
- Train PC 0x100 with 8 taken updates, then look up -> BHT=4'b1111 and PHT[{0,1111}]=2'b11, so taken=1.
  - One further not-taken update -> PHT[{0,1111}]=2'b10, BHT=4'b1110.
  - Next lookup -> taken=0 (PHT[{0,1110}]=01).
- Saturation: 10 not-taken updates on PC 0x104 -> counter at history 0000 stays 2'b00 with no wrap.
  - PC 0x100 entries are unchanged, since idx 1 is distinct.
- Aliasing: train PC 0x100 (as above), then look up PC 0x200 -> same idx 0, so taken=1.
- Same-cycle lookup and update of PC 0x100 where the counter goes 01->10 -> lookup returns taken=0.
  - The following lookup, after history is realigned by training, reflects the new value.
- Hold rdy_in low for 5 cycles with if2pred_en and rob2pred_en high -> no table change, valid and taken frozen.
  - Assert rst_in mid-INIT at sweep_ptr=500 -> sweep restarts and takes a full 1024 cycles.
  - With PRED_STATS_EN: counters equal the accepted lookup and mispredict counts exactly.
